// File: rtl/multi_seq_detector.sv
// Multi-channel serial pattern detector.
//
// Each of CHANNELS single-bit serial inputs is compared against its own
// run-time-programmable pattern of 1..MAX_LEN bits. Matching may be overlapping
// or non-overlapping per channel. Each channel produces a registered one-cycle
// hit pulse and keeps a saturating match counter.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          asynchronous active-high reset, clears all state
//   enable_i       global sample enable; low freezes every channel
//   din_i          serial input bits, bit c feeds channel c
//   cfg_we_i       configuration write strobe
//   cfg_ch_i       channel being configured (out-of-range writes are ignored)
//   cfg_pattern_i  pattern; bit len-1 is the first bit received, bit 0 the last
//   cfg_len_i      pattern length; 0 or > MAX_LEN disables the channel
//   cfg_overlap_i  1 = overlapping matches allowed
//   cnt_clr_i      synchronous clear of all match counters
//   hit_o          registered one-cycle match pulse per channel
//   hit_any_o      registered OR of the hit bits, aligned with hit_o
//   match_cnt_o    counters, channel c at [c*CNT_W +: CNT_W]
module multi_seq_detector #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MAX_LEN  = 8,
  parameter int unsigned CNT_W    = 8,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [CHANNELS-1:0]       din_i,
  input  logic                      cfg_we_i,
  input  logic [CH_W-1:0]           cfg_ch_i,
  input  logic [MAX_LEN-1:0]        cfg_pattern_i,
  input  logic [LEN_W-1:0]          cfg_len_i,
  input  logic                      cfg_overlap_i,
  input  logic                      cnt_clr_i,
  output logic [CHANNELS-1:0]       hit_o,
  output logic                      hit_any_o,
  output logic [CHANNELS*CNT_W-1:0] match_cnt_o
);

  logic [CHANNELS-1:0] hit_next;
  logic                hit_any_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    // The oldest history bit always shifts out before it can be compared,
    // so only MAX_LEN-1 bits are kept.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               hit_q, hit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_p1;
    logic               sel;
    logic               len_ok;
    logic               filled;
    logic               match;

    assign sel     = cfg_we_i && (cfg_ch_i == CH_W'(c));
    assign cand    = {hist_q, din_i[c]};
    assign len_ok  = (len_q != '0) && (len_q <= LEN_W'(MAX_LEN));
    assign fill_p1 = {1'b0, fill_q} + (LEN_W + 1)'(1);
    // fill >= len-1, i.e. the candidate holds len bits seen since the last clear
    assign filled  = fill_p1 >= {1'b0, len_q};

    always_comb begin
      mask = '0;
      for (int unsigned b = 0; b < MAX_LEN; b++) begin
        mask[b] = (b < 32'(len_q));
      end
    end

    assign match = len_ok && filled && ((cand & mask) == (pattern_q & mask));

    always_comb begin
      pattern_d = pattern_q;
      len_d     = len_q;
      overlap_d = overlap_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      hit_d     = 1'b0;
      cnt_d     = cnt_q;

      if (sel) begin
        // This cycle's input bit is dropped; matching restarts from scratch.
        pattern_d = cfg_pattern_i;
        len_d     = cfg_len_i;
        overlap_d = cfg_overlap_i;
        hist_d    = '0;
        fill_d    = '0;
      end else if (enable_i) begin
        hist_d = cand[MAX_LEN-2:0];
        hit_d  = match;
        if (match && !overlap_q) begin
          fill_d = '0;
        end else if (fill_q < LEN_W'(MAX_LEN)) begin
          fill_d = fill_p1[LEN_W-1:0];
        end
      end

      if (cnt_clr_i) begin
        cnt_d = '0;
      end else if (hit_d && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        pattern_q <= '0;
        len_q     <= '0;
        overlap_q <= 1'b0;
        hist_q    <= '0;
        fill_q    <= '0;
        hit_q     <= 1'b0;
        cnt_q     <= '0;
      end else begin
        pattern_q <= pattern_d;
        len_q     <= len_d;
        overlap_q <= overlap_d;
        hist_q    <= hist_d;
        fill_q    <= fill_d;
        hit_q     <= hit_d;
        cnt_q     <= cnt_d;
      end
    end

    assign hit_next[c]                     = hit_d;
    assign hit_o[c]                        = hit_q;
    assign match_cnt_o[c*CNT_W +: CNT_W]   = cnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_any_q <= 1'b0;
    end else begin
      hit_any_q <= |hit_next;
    end
  end

  assign hit_any_o = hit_any_q;

endmodule

// File: tb/tb_multi_seq_detector.sv
// Scoreboard bench for multi_seq_detector (4 channels, MAX_LEN 8, 2-bit counters).
module tb_multi_seq_detector;

  localparam int unsigned CH  = 4;
  localparam int unsigned ML  = 8;
  localparam int unsigned CW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [CH-1:0] din;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [ML-1:0] cfg_pattern;
  logic [3:0]    cfg_len;
  logic          cfg_overlap;
  logic          cnt_clr;
  logic [CH-1:0] hit;
  logic          hit_any;
  logic [CH*CW-1:0] match_cnt;

  multi_seq_detector #(
    .CHANNELS(CH),
    .MAX_LEN (ML),
    .CNT_W   (CW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .din_i        (din),
    .cfg_we_i     (cfg_we),
    .cfg_ch_i     (cfg_ch),
    .cfg_pattern_i(cfg_pattern),
    .cfg_len_i    (cfg_len),
    .cfg_overlap_i(cfg_overlap),
    .cnt_clr_i    (cnt_clr),
    .hit_o        (hit),
    .hit_any_o    (hit_any),
    .match_cnt_o  (match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0]    hit;
    logic             any;
    logic [CH*CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   exp_cnt[CH];
  int   checks = 0;
  int   errors = 0;

  // Monitor: after every rising edge, pop the expected response and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (hit !== e.hit) begin
          errors++;
          $display("FAIL hit: got %b expected %b at %0t", hit, e.hit, $time);
        end
        checks++;
        if (hit_any !== e.any) begin
          errors++;
          $display("FAIL hit_any: got %b expected %b at %0t", hit_any, e.any, $time);
        end
        checks++;
        if (match_cnt !== e.cnt) begin
          errors++;
          $display("FAIL match_cnt: got %h expected %h at %0t", match_cnt, e.cnt, $time);
        end
      end
    end
  end

  // One sample cycle: drive din, push the hand-computed hit vector; counters
  // follow from the expected hits, cnt_clr and reset.
  task automatic step(input logic [CH-1:0] d, input logic [CH-1:0] h);
    exp_t e;
    din = d;
    for (int c = 0; c < CH; c++) begin
      if (rst || cnt_clr) exp_cnt[c] = 0;
      else if (h[c] && exp_cnt[c] < 3) exp_cnt[c]++;
    end
    e.hit = h;
    e.any = |h;
    for (int c = 0; c < CH; c++) e.cnt[c*CW +: CW] = CW'(exp_cnt[c]);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [ML-1:0] pat, input logic [3:0] len,
                     input logic ov, input logic [CH-1:0] d, input logic [CH-1:0] h);
    cfg_we      = 1'b1;
    cfg_ch      = ch;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    step(d, h);
    cfg_we      = 1'b0;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (hit !== '0 || hit_any !== 1'b0 || match_cnt !== '0) begin
      errors++;
      $display("FAIL %s: got hit=%b any=%b cnt=%h expected all zero", name, hit, hit_any,
               match_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; din = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    for (int c = 0; c < CH; c++) exp_cnt[c] = 0;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;

    // All channels disabled after reset
    step(4'b1111, 4'b0000);
    step(4'b0101, 4'b0000);

    // Overlap: 1010 on ch0, stream 101010
    cfg(2'd0, 8'b1010, 4'd4, 1'b1, 4'b0000, 4'b0000);
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0001);
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0001);

    // Non-overlap: same stream extended to 10101010, counters cleared first
    cnt_clr = 1'b1;
    step(4'b0000, 4'b0000);
    cnt_clr = 1'b0;
    cfg(2'd0, 8'b1010, 4'd4, 1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      step({3'b000, ~1'(i % 2)}, (i == 3 || i == 7) ? 4'b0001 : 4'b0000);
    end

    // Multi-channel and length edges
    cfg(2'd1, 8'b111, 4'd3, 1'b1, 4'b0000, 4'b0000);
    cfg(2'd2, 8'b10,  4'd2, 1'b0, 4'b0000, 4'b0000);
    cfg(2'd3, 8'hFF,  4'd0, 1'b1, 4'b0000, 4'b0000);
    step(4'b0110, 4'b0000);
    step(4'b0010, 4'b0100);
    step(4'b1010, 4'b0010);
    step(4'b1010, 4'b0010);
    for (int i = 0; i < 8; i++) begin
      logic r;
      r = 1'($urandom);
      step({r, 3'b000}, 4'b0000);
    end

    // Saturation and clear: len 1 pattern 1, din0 held at 1
    cnt_clr = 1'b1;
    step(4'b0000, 4'b0000);
    cnt_clr = 1'b0;
    cfg(2'd0, 8'b1, 4'd1, 1'b1, 4'b0000, 4'b0000);
    repeat (6) step(4'b0001, 4'b0001);
    cnt_clr = 1'b1;
    step(4'b0001, 4'b0001);
    cnt_clr = 1'b0;

    // Reconfigure after three bits of 1010: stale history must not match
    cfg(2'd0, 8'b1010, 4'd4, 1'b1, 4'b0000, 4'b0000);
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0001, 4'b0000);
    cfg(2'd0, 8'b1010, 4'd4, 1'b1, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0001);

    // Enable drop mid-pattern: frozen bits are ignored
    cfg(2'd0, 8'b1010, 4'd4, 1'b1, 4'b0000, 4'b0000);
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0000);
    enable = 1'b0;
    step(4'b0001, 4'b0000);
    step(4'b0001, 4'b0000);
    enable = 1'b1;
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0001);

    // Reset one bit before a match completes
    cfg(2'd0, 8'b1010, 4'd4, 1'b1, 4'b0000, 4'b0000);
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0001, 4'b0000);
    din = 4'b0000;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    step(4'b0000, 4'b0000);
    rst = 1'b0;
    // Patterns were lost: nothing matches until reprogrammed
    step(4'b0010, 4'b0000);
    step(4'b0010, 4'b0000);
    cfg(2'd0, 8'b110, 4'd3, 1'b0, 4'b0010, 4'b0000);
    step(4'b0011, 4'b0000);
    step(4'b0011, 4'b0000);
    step(4'b0010, 4'b0001);
    step(4'b0000, 4'b0000);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_seq_detector.md
# multi_seq_detector

Parametrised multi-channel serial pattern detector, the generalised successor of the team's fixed three-channel detector. Each of CHANNELS independent single-bit inputs is checked against a run-time-programmable pattern of 1..MAX_LEN bits, with overlapping or non-overlapping matching selected per channel. Each channel has a registered one-cycle hit pulse and a saturating match counter. It sits between the serial input front-ends and the control/status logic.

## Interface
- CHANNELS, 4: number of independent detector channels (≥1)
- MAX_LEN, 8: maximum pattern length in bits (≥2)
- CNT_W, 8: width of each per-channel match counter
- Derived: CH_W = max(1, clog2(CHANNELS)); LEN_W = clog2(MAX_LEN+1)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  global sample enable; when low, all channels freeze
- din  in  CHANNELS  serial input bits; bit c belongs to channel c
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  CH_W  channel being configured
- cfg_pattern  in  MAX_LEN  pattern; bit len-1 is the first bit received, bit 0 the last
- cfg_len  in  LEN_W  pattern length; 0 or >MAX_LEN means channel disabled
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
- cnt_clr  in  1  synchronous clear of all match counters
- hit  out  CHANNELS  registered one-cycle match pulse per channel
- hit_any  out  1  registered OR of all hit bits
- match_cnt  out  CHANNELS*CNT_W  counters; channel c occupies bits [c*CNT_W +: CNT_W]

## Operation
- Per-channel state: pattern, len, overlap, history shift register hist[MAX_LEN-1:0], fill counter (0..MAX_LEN), hit flop, match counter.
- Reset values: len=0 (all channels disabled), pattern=0, overlap=0, hist=0, fill=0, hit=0, hit_any=0, all match_cnt=0.
- Sample cycle (enable=1, channel not being configured):
  - candidate = {hist[MAX_LEN-2:0], din[c]}.
  - match = (1 ≤ len ≤ MAX_LEN) and (fill ≥ len-1) and (low len bits of candidate == low len bits of pattern).
  - hist ← candidate.
  - fill ← min(fill+1, MAX_LEN). Exception: if match and overlap=0, fill ← 0, so the next match needs len fresh bits.
  - hit[c] ← match.
- enable=0: hist, fill and counters hold; hit ← 0 for all channels.
- Configuration (cfg_we=1, cfg_ch < CHANNELS):
  - Channel cfg_ch latches cfg_pattern, cfg_len and cfg_overlap.
  - Its hist and fill are cleared to 0 and its hit ← 0.
  - Its din bit in that cycle is discarded.
  - Other channels operate normally.
  - cfg_ch ≥ CHANNELS: write ignored.
- Counters:
  - On each cycle where hit[c] is loaded with 1, match_cnt[c] increments.
  - Counters saturate at 2^CNT_W−1 and hold there.
  - cnt_clr=1 zeroes all counters and takes priority over a simultaneous increment. hit itself is unaffected by cnt_clr.
- hit_any ← OR of the next-state hit bits, so it is aligned with hit.

## Timing
- Latency: the completing bit is sampled at edge N. hit[c], hit_any and the incremented match_cnt[c] are visible after edge N, for exactly one cycle (counter persists).
- Back-to-back hits on consecutive cycles are possible in overlap mode, e.g. pattern 11, len 2.
- A new configuration takes effect for bits sampled from the edge after the cfg_we edge. The first possible hit comes len edges after that.
- Reset asserted mid-stream: all outputs go to reset values immediately (asynchronously). Programmed patterns are lost; channels must be reconfigured.
- No combinational path from any input to any output.

## Test plan
- Overlap: ch0 pattern 4'b1010, len 4, overlap=1; din[0] = 1,0,1,0,1,0 → hit[0] high after the 4th and 6th bits only; match_cnt[0]=2.
- Non-overlap: same stream and pattern with overlap=0 → hit after the 4th bit only. Extending the stream with 1,0 gives a second hit after the 8th bit; match_cnt[0]=2.
- Multi-channel and length edges:
  - Setup: ch1 = 3'b111, overlap; ch2 = 2'b10; ch3 len 0.
  - Stimulus: din[1] = 1,1,1,1; din[2] = 1,0; din[3] random.
  - Required response: hit[1] after bits 3 and 4; hit[2] after bit 2; hit[3] never; hit_any equals the OR of the hit bits.
- Saturation and clear: CNT_W=2, pattern 1, len 1, din held at 1 for 6 cycles → match_cnt 1,2,3,3,3,3. Then cnt_clr on a hit cycle → 0.
- Reconfigure/enable:
  - Reconfigure ch0 after 3 bits of 1010 → no hit from the partial history.
  - Drop enable for 2 cycles mid-pattern → the match completes on the later bits with no extra hits.
- Reset mid-stream: assert reset one bit before a match completes → hit, hit_any and counters stay 0. After release and reprogramming, a fresh pattern is detected normally.
